// File: rtl/instr_fetch.sv
// Instruction fetch unit for the LEG CPU.
// Owns the program counter and fetches 32-bit instruction words over a
// req/ack handshake. The word is held for the control unit until it is retired.
// On retirement the next PC is computed from pc_sel. A misaligned target
// parks the unit in a sticky FAULT state, which only reset clears.
module instr_fetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_update,
  input  logic [1:0]        pc_sel,
  input  logic [63:0]       k,
  input  logic [63:0]       reg_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    FAULT
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              fault_q;

  logic [63:0]       kShift;
  logic [ADDR_W-1:0] nextPc_d;

  // Candidate next PC for a retirement. All adds wrap modulo 2^ADDR_W.
  always_comb begin
    kShift   = k << 2;
    nextPc_d = pc_q;
    case (pc_sel)
      2'd1:    nextPc_d = pc_q + ADDR_W'(4);
      2'd2:    nextPc_d = reg_target[ADDR_W-1:0];
      2'd3:    nextPc_d = pc_q + kShift[ADDR_W-1:0];
      default: nextPc_d = pc_q;
    endcase
  end

  // Fetch FSM, which also holds the PC, the instruction and the status registers.
  // Reset aborts any outstanding fetch immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
        end
        REQ, WAIT: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= VALID;
          end else begin
            state_q <= WAIT;
          end
        end
        VALID: begin
          if (pc_update && (pc_sel != 2'd0)) begin
            pc_q    <= nextPc_d;
            valid_q <= 1'b0;
            if (nextPc_d[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              state_q <= REQ;
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (state_q == REQ) || (state_q == WAIT);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch.
// A behavioural PC model and a memory model drive randomized retirements
// and randomized memory wait states.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_update;
  logic [1:0]  pc_sel;
  logic [63:0] k;
  logic [63:0] reg_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] pc;
  logic        fault;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] expPc;
  logic [31:0] expInstr;

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_update   (pc_update),
    .pc_sel      (pc_sel),
    .k           (k),
    .reg_target  (reg_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .fault       (fault)
  );

  // Contents of the instruction memory, as a pure function of the address.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'h0) return 32'h91000421;
    return a[31:0] ^ a[63:32] ^ 32'hA5C31E77;
  endfunction

  // Advance one cycle, then sample just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count a comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Serve a fetch that is currently in REQ, after the given number of wait cycles.
  task automatic doFetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      checkOutput("waitReq", imem_req, 1);
      checkOutput("waitAddr", imem_addr, expPc);
      checkOutput("waitValid", instr_valid, 0);
      imem_ack = 1'b0;
      tick();
    end
    checkOutput("reqReq", imem_req, 1);
    checkOutput("reqAddr", imem_addr, expPc);
    imem_ack   = 1'b1;
    imem_rdata = memWord(expPc);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    expInstr   = memWord(expPc);
    checkOutput("fetchInstr", instr, expInstr);
    checkOutput("fetchValid", instr_valid, 1);
    checkOutput("fetchReqLow", imem_req, 0);
    checkOutput("fetchPc", pc, expPc);
  endtask

  // Retire the current instruction and check the resulting next PC.
  task automatic retire(input logic [1:0] sel, input logic [63:0] kv,
                        input logic [63:0] rt, input int waits);
    logic [63:0] nxt;
    case (sel)
      2'd1:    nxt = expPc + 64'd4;
      2'd2:    nxt = rt;
      2'd3:    nxt = expPc + kv * 64'd4;
      default: nxt = expPc;
    endcase
    pc_update  = 1'b1;
    pc_sel     = sel;
    k          = kv;
    reg_target = rt;
    tick();
    pc_update = 1'b0;
    if (sel == 2'd0) begin
      checkOutput("holdPc", pc, expPc);
      checkOutput("holdInstr", instr, expInstr);
      checkOutput("holdValid", instr_valid, 1);
      checkOutput("holdReq", imem_req, 0);
    end else begin
      expPc = nxt;
      checkOutput("nextPc", pc, expPc);
      checkOutput("nextValid", instr_valid, 0);
      if (nxt[1:0] != 2'b00) begin
        checkOutput("faultSet", fault, 1);
        checkOutput("faultReq", imem_req, 0);
      end else begin
        checkOutput("nextReq", imem_req, 1);
        checkOutput("nextAddr", imem_addr, expPc);
        doFetch(waits);
      end
    end
  endtask

  // Sit in VALID with stray acks and noise on the inputs; nothing may change.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      pc_sel     = 2'($urandom_range(0, 3));
      tick();
      checkOutput("idleInstr", instr, expInstr);
      checkOutput("idleValid", instr_valid, 1);
      checkOutput("idleReq", imem_req, 0);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    int          kk;
    logic [1:0]  sel;
    logic [63:0] kv;
    logic [63:0] rt;

    rst_n      = 1'b0;
    pc_update  = 1'b0;
    pc_sel     = 2'd0;
    k          = '0;
    reg_target = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    expPc      = 64'h0;
    expInstr   = 32'h0;
    tick();
    tick();
    checkOutput("rstPc", pc, 64'h0);
    checkOutput("rstInstr", instr, 0);
    checkOutput("rstValid", instr_valid, 0);
    checkOutput("rstReq", imem_req, 0);
    checkOutput("rstFault", fault, 0);

    rst_n = 1'b1;
    tick();
    checkOutput("reqNoValid", instr_valid, 0);
    doFetch(0);
    checkOutput("firstInstr", instr, 64'h91000421);

    retire(2'd2, 64'h0, 64'h100, 0);
    retire(2'd1, 64'h0, 64'h0, 3);
    checkOutput("pcPlus4", pc, 64'h104);
    retire(2'd2, 64'h0, 64'h100, 0);
    retire(2'd3, -64'sd2, 64'h0, 1);
    checkOutput("kNeg", pc, 64'hF8);
    retire(2'd2, 64'h0, 64'h0, 0);
    retire(2'd3, -64'sd1, 64'h0, 0);
    checkOutput("kWrap", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    retire(2'd2, 64'h0, 64'h2000, 2);
    checkOutput("brTarget", pc, 64'h2000);
    retire(2'd0, 64'h0, 64'h0, 0);
    retire(2'd0, 64'h0, 64'h0, 0);
    applyStimulus(3);

    for (int n = 0; n < 60; n++) begin
      sel = 2'($urandom_range(0, 3));
      kk  = int'($urandom_range(0, 200)) - 100;
      kv  = longint'(kk);
      rt  = {$urandom, $urandom} & ~64'h3;
      retire(sel, kv, rt, int'($urandom_range(0, 3)));
      applyStimulus(int'($urandom_range(0, 2)));
    end

    retire(2'd2, 64'h0, 64'h2002, 0);
    for (int n = 0; n < 4; n++) begin
      pc_update  = 1'b1;
      pc_sel     = 2'($urandom_range(1, 3));
      reg_target = 64'h4000;
      imem_ack   = 1'($urandom_range(0, 1));
      tick();
      checkOutput("faultHold", fault, 1);
      checkOutput("faultPc", pc, 64'h2002);
      checkOutput("faultNoReq", imem_req, 0);
      checkOutput("faultNoValid", instr_valid, 0);
    end
    pc_update = 1'b0;
    imem_ack  = 1'b0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expPc = 64'h0;
    tick();
    doFetch(0);
    pc_update = 1'b1;
    pc_sel    = 2'd1;
    tick();
    pc_update = 1'b0;
    tick();
    checkOutput("midWaitReq", imem_req, 1);
    checkOutput("midWaitAddr", imem_addr, 64'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortReq", imem_req, 0);
    checkOutput("abortPc", pc, 64'h0);
    checkOutput("abortFault", fault, 0);
    tick();
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    tick();
    checkOutput("lateAckValid", instr_valid, 0);
    checkOutput("lateAckInstr", instr, 0);
    expPc = 64'h0;
    doFetch(1);
    checkOutput("refetchInstr", instr, 64'h91000421);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
